logic_unit_cc: RTL and testbench
================================

Name: logic_unit_cc

Overview:
- Parametrised, registered successor to the fixed 64-bit combinational AND with condition flags, for the Execute stage.
- Performs one of four bitwise operations on two WIDTH-bit operands.
- Holds the result in a single output register with valid/ready backpressure.
- Maintains an architectural condition-code register (ZF, SF, OF) that is updated only on request, plus a wrapping count of completed operations.

Parameters:
- WIDTH, 64, operand/result width in bits (>= 2).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous, active-high
- in_valid  input  1  operand bundle valid
- in_ready  output  1  unit can accept a bundle this cycle
- a  input  WIDTH  operand A, signed
- b  input  WIDTH  operand B, signed
- op  input  2  operation select: 0 AND, 1 XOR, 2 OR, 3 ANDN (a & ~b)
- set_cc  input  1  when high, this operation updates cc
- out_valid  output  1  result register holds an unconsumed result
- out_ready  input  1  consumer accepts the result this cycle
- result  output  WIDTH  registered result
- res_flags  output  3  flags of the current result: [0] ZF, [1] SF, [2] OF
- cc  output  3  architectural condition codes, same bit order as res_flags
- op_count  output  CNT_W  number of results consumed, wrapping

Behaviour:
- Reset (synchronous, active-high): out_valid=0, result=0, res_flags=3'b000, cc=3'b001 (ZF set, matching a zero result), op_count=0. Reset dominates every other input in the same cycle and drops any in-flight result.
- Acceptance rule: in_ready = !out_valid || out_ready. This is combinational from out_valid and out_ready only; it never depends on in_valid.
- Input handshake: fire_in = in_valid && in_ready. On fire_in, at the next rising edge:
  - result <= f(op, a, b)
  - res_flags <= {OF=0, SF=f[WIDTH-1], ZF=(f==0)}
  - out_valid <= 1
- Latency: 1 cycle from fire_in to out_valid.
- Throughput: 1 operation per cycle while out_ready is held high.
- Output handshake: fire_out = out_valid && out_ready. On fire_out without a simultaneous fire_in, out_valid <= 0 at the edge. On fire_out with a simultaneous fire_in, the register is reloaded back-to-back and out_valid stays 1.
- Stall: while out_valid=1 and out_ready=0, result and res_flags hold stable and in_ready=0. Any in_valid in that state is ignored; the producer must hold its bundle.
- CC update: on fire_in with set_cc=1, cc <= the flags of the new result on the same edge as result is loaded. With set_cc=0, cc holds. cc is never changed by fire_out or by stalls.
- OF is always 0 for every op. The bit is reserved so this unit's cc lines up with the arithmetic unit's cc.
- op_count increments by 1 on each fire_out and wraps from 2^CNT_W-1 to 0.
- Opcode map: op is 2 bits, so there are no illegal codes. All four encodings are valid.
- Arithmetic: purely bitwise, no carry. Signedness affects only SF (the MSB).
- No combinational path from a, b, op or set_cc to any output.

Test Plan:
- Reset then idle: assert rst for 2 cycles with in_valid=1 -> out_valid=0, result=0, cc=3'b001, op_count=0, in_ready=1 throughout.
- All four ops with WIDTH=64, a=64'hF0F0_0000_FFFF_0001, b=64'h0FF0_0000_00FF_0001, set_cc=1, out_ready=1:
  - AND -> 64'h00F0_0000_00FF_0001, cc=000
  - XOR -> 64'hFF00_0000_FF00_0000, cc=010
  - OR -> 64'hFFF0_0000_FFFF_0001, cc=010
  - ANDN -> 64'hF000_0000_FF00_0000, cc=010
  - Each result appears exactly 1 cycle after its issue.
- Zero result and set_cc gating:
  - AND of 64'hAAAA... with 64'h5555..., set_cc=1 -> result=0, res_flags=001, cc=001.
  - Next, XOR of 64'h8000...0 with 0, set_cc=0 -> res_flags=010, while cc stays 001.
- Backpressure: issue op A, hold out_ready=0 for 3 cycles while presenting op B -> in_ready=0, result/res_flags frozen at A. Raise out_ready -> A consumed, B loaded on that same edge, op_count +1 per consume, no bundle lost or duplicated.
- Back-to-back streaming: 10 ops with in_valid=out_ready=1 every cycle -> 10 consecutive valid results in order, op_count=10. With CNT_W=4, 20 consumes -> op_count=4 (wraps through 0).
- Reset mid-operation: rst high while out_valid=1 and out_ready=0 -> next cycle out_valid=0, cc=001, op_count=0, and the pending result is never delivered.

Source files
------------

// File: rtl/logic_unit_cc.sv
// logic_unit_cc: registered bitwise logic unit for the Execute stage.
// One of AND / XOR / OR / ANDN on two WIDTH-bit operands, a single output
// register with valid/ready backpressure, result flags, an architectural
// condition-code register updated on request, and a wrapping count of
// consumed results.

// Per-bit slice of the logic function. There is no carry, so every bit is
// independent and the datapath is just an array of these slices.
module logic_unit_cc_lane (
    input  logic [1:0] op,
    input  logic       a,
    input  logic       b,
    output logic       f
);

    // Select the bitwise operation for this bit position
    always_comb begin
        f = 1'b0;
        case (op)
            2'd0:    f = a & b;
            2'd1:    f = a ^ b;
            2'd2:    f = a | b;
            default: f = a & ~b;
        endcase
    end

endmodule

module logic_unit_cc #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             set_cc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       res_flags,
    output logic [2:0]       cc,
    output logic [CNT_W-1:0] op_count
);

    // Flag bit positions, shared by res_flags and cc
    localparam int ZF = 0;
    localparam int SF = 1;
    localparam int OF = 2;

    // Reset value of cc: ZF set, consistent with the zero reset result
    localparam logic [2:0] CC_RESET = 3'b001;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [1:0]       op;
        logic             set_cc;
    } req_t;

    req_t             req;
    logic [WIDTH-1:0] f;
    logic [2:0]       f_flags;
    logic             fire_in;
    logic             fire_out;

    assign req = '{a: a, b: b, op: op, set_cc: set_cc};

    // Bit-sliced datapath
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        logic_unit_cc_lane u_lane (
            .op (req.op),
            .a  (req.a[i]),
            .b  (req.b[i]),
            .f  (f[i])
        );
    end

    // Flags of the value about to be loaded. OF is reserved (always 0) so the
    // cc layout matches the arithmetic unit's.
    always_comb begin
        f_flags     = 3'b000;
        f_flags[ZF] = ~|f;
        f_flags[SF] = f[WIDTH-1];
        f_flags[OF] = 1'b0;
    end

    // Accept when the register is empty or is being drained this cycle;
    // deliberately independent of in_valid.
    assign in_ready = !out_valid || out_ready;
    assign fire_in  = in_valid && in_ready;
    assign fire_out = out_valid && out_ready;

    // Output register, condition codes and consume counter
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            res_flags <= 3'b000;
            cc        <= CC_RESET;
            op_count  <= '0;
        end else begin
            if (fire_in) begin
                result    <= f;
                res_flags <= f_flags;
                out_valid <= 1'b1;
                if (req.set_cc) cc <= f_flags;
            end else if (fire_out) begin
                out_valid <= 1'b0;
            end
            if (fire_out) op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_logic_unit_cc.sv
// Self-checking bench for logic_unit_cc. Every accepted bundle pushes its
// expected result/flags/cc into a scoreboard; every consumed result pops and
// compares. A second instance with CNT_W=4 shares the inputs to check wrap.
module tb_logic_unit_cc;

    localparam int W = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [1:0]    op;
    logic          set_cc;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [2:0]    res_flags;
    logic [2:0]    cc;
    logic [15:0]   op_count;

    logic          in_ready4;
    logic          out_valid4;
    logic [W-1:0]  result4;
    logic [2:0]    res_flags4;
    logic [2:0]    cc4;
    logic [3:0]    cnt4;

    always #5 clk = ~clk;

    logic_unit_cc #(.WIDTH(W), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .set_cc(set_cc),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .res_flags(res_flags), .cc(cc), .op_count(op_count)
    );

    logic_unit_cc #(.WIDTH(W), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .a(a), .b(b), .op(op), .set_cc(set_cc),
        .out_valid(out_valid4), .out_ready(out_ready), .result(result4),
        .res_flags(res_flags4), .cc(cc4), .op_count(cnt4)
    );

    typedef struct {
        logic [W-1:0] res;
        logic [2:0]   flags;
        logic [2:0]   cc;
    } exp_t;

    exp_t        sb[$];
    logic [2:0]  model_cc;
    logic [15:0] model_cnt;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_pops   = 0;

    function automatic logic [W-1:0] calc(input logic [1:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
        case (o)
            2'd0:    return x & y;
            2'd1:    return x ^ y;
            2'd2:    return x | y;
            default: return x & ~y;
        endcase
    endfunction

    function automatic logic [2:0] flags_of(input logic [W-1:0] v);
        return {1'b0, v[W-1], (v == '0)};
    endfunction

    function automatic logic [W-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // One clock: sample at negedge (pop/compare, then push), re-drive after posedge
    task automatic step();
        exp_t         e;
        logic [W-1:0] f;
        logic [2:0]   fl;
        @(negedge clk);
        if (out_valid && out_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_empty: delivered result %h, nothing pending", result);
            end else begin
                e = sb.pop_front();
                if ({result, res_flags, cc, op_count} !== {e.res, e.flags, e.cc, model_cnt}) begin
                    n_fail++;
                    $display("FAIL sb_pop: got res=%h fl=%b cc=%b cnt=%0d, want res=%h fl=%b cc=%b cnt=%0d",
                             result, res_flags, cc, op_count, e.res, e.flags, e.cc, model_cnt);
                end
            end
            n_checks++;
            if (cnt4 !== model_cnt[3:0]) begin
                n_fail++;
                $display("FAIL cnt4: got %0d want %0d", cnt4, model_cnt[3:0]);
            end
            model_cnt++;
            n_pops++;
        end
        if (in_valid && in_ready) begin
            f  = calc(op, a, b);
            fl = flags_of(f);
            if (set_cc) model_cc = fl;
            sb.push_back('{f, fl, model_cc});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        sb.delete();
        model_cc  = 3'b001;
        model_cnt = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic drive(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic s);
        in_valid = 1'b1;
        op = o; a = x; b = y; set_cc = s;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        a = '1; b = '1; op = 2'd2; set_cc = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if ({out_valid, result, cc, op_count, in_ready} !== {1'b0, 64'h0, 3'b001, 16'h0, 1'b1}) begin
                n_fail++;
                $display("FAIL reset: ov=%b res=%h cc=%b cnt=%0d ir=%b, want 0 0 001 0 1",
                         out_valid, result, cc, op_count, in_ready);
            end
            @(posedge clk);
        end
        #1;
        rst = 1'b0; in_valid = 1'b0;
        model_reset();
    endtask

    task automatic test_ops();
        logic [W-1:0] ea[4];
        logic [2:0]   ec[4];
        ea[0] = 64'h00F0_0000_00FF_0001; ec[0] = 3'b000;
        ea[1] = 64'hFF00_0000_FF00_0000; ec[1] = 3'b010;
        ea[2] = 64'hFFF0_0000_FFFF_0001; ec[2] = 3'b010;
        ea[3] = 64'hF000_0000_FF00_0000; ec[3] = 3'b010;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(2'(i), 64'hF0F0_0000_FFFF_0001, 64'h0FF0_0000_00FF_0001, 1'b1);
            step();
            in_valid = 1'b0;
            n_checks++;
            if ({out_valid, result, cc} !== {1'b1, ea[i], ec[i]}) begin
                n_fail++;
                $display("FAIL op%0d: ov=%b res=%h cc=%b, want 1 %h %b",
                         i, out_valid, result, cc, ea[i], ec[i]);
            end
            step();
        end
    endtask

    task automatic test_zero_cc();
        out_ready = 1'b1;
        drive(2'd0, {16{4'hA}}, {16{4'h5}}, 1'b1);
        step();
        in_valid = 1'b0;
        n_checks++;
        if ({result, res_flags, cc} !== {64'h0, 3'b001, 3'b001}) begin
            n_fail++;
            $display("FAIL zero: res=%h fl=%b cc=%b, want 0 001 001", result, res_flags, cc);
        end
        step();
        drive(2'd1, 64'h8000_0000_0000_0000, 64'h0, 1'b0);
        step();
        in_valid = 1'b0;
        n_checks++;
        if ({res_flags, cc} !== {3'b010, 3'b001}) begin
            n_fail++;
            $display("FAIL no_set_cc: fl=%b cc=%b, want 010 001", res_flags, cc);
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           pops0;
        logic [15:0]  cnt0;
        ra = calc(2'd2, 64'h1234_0000_0000_0000, 64'h0000_0000_0000_5678);
        rb = calc(2'd3, 64'hFFFF_FFFF_0000_0000, 64'h0F0F_0000_0000_0000);
        pops0 = n_pops; cnt0 = op_count;
        out_ready = 1'b0;
        drive(2'd2, 64'h1234_0000_0000_0000, 64'h0000_0000_0000_5678, 1'b1);
        step();
        drive(2'd3, 64'hFFFF_FFFF_0000_0000, 64'h0F0F_0000_0000_0000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({in_ready, out_valid, result, res_flags} !== {1'b0, 1'b1, ra, flags_of(ra)}) begin
                n_fail++;
                $display("FAIL stall%0d: ir=%b ov=%b res=%h fl=%b, want 0 1 %h %b",
                         i, in_ready, out_valid, result, res_flags, ra, flags_of(ra));
            end
            step();
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, result, op_count} !== {1'b1, rb, 16'(cnt0 + 1)}) begin
            n_fail++;
            $display("FAIL reload: ov=%b res=%h cnt=%0d, want 1 %h %0d",
                     out_valid, result, op_count, rb, cnt0 + 1);
        end
        step();
        n_checks++;
        if ((n_pops - pops0) != 2 || op_count !== 16'(cnt0 + 2) || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: pops=%0d cnt=%0d ov=%b, want 2 %0d 0",
                     n_pops - pops0, op_count, out_valid, cnt0 + 2);
        end
    endtask

    task automatic test_back_to_back();
        int pops0;
        do_reset();
        pops0 = n_pops;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(2'($urandom_range(0, 3)), rnd64(), rnd64(), 1'($urandom_range(0, 1)));
            step();
            n_checks++;
            if (out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_valid%0d: ov=%b, want 1", i, out_valid);
            end
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if ((n_pops - pops0) != 10 || op_count !== 16'd10) begin
            n_fail++;
            $display("FAIL b2b_count: pops=%0d cnt=%0d, want 10 10", n_pops - pops0, op_count);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(2'(i % 4), rnd64(), rnd64(), 1'b1);
            step();
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if ({op_count, cnt4} !== {16'd20, 4'd4}) begin
            n_fail++;
            $display("FAIL wrap: cnt=%0d cnt4=%0d, want 20 4", op_count, cnt4);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            op = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 5) == 0) ? '0 : rnd64();
            b = rnd64();
            set_cc = 1'($urandom_range(0, 1));
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        n_checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_drain: pending=%0d ov=%b, want 0 0", sb.size(), out_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        drive(2'd1, rnd64(), rnd64(), 1'b1);
        step();
        out_ready = 1'b0;
        drive(2'd2, 64'h8000_0000_0000_0001, 64'h0, 1'b1);
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pending: ov=%b, want 1", out_valid);
        end
        do_reset();
        n_checks++;
        if ({out_valid, cc, op_count} !== {1'b0, 3'b001, 16'd0}) begin
            n_fail++;
            $display("FAIL mid_reset: ov=%b cc=%b cnt=%0d, want 0 001 0", out_valid, cc, op_count);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        n_checks++;
        if (op_count !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_ghost: cnt=%0d, want 0", op_count);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_ops();
        test_zero_cc();
        test_backpressure();
        test_back_to_back();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
